// File: rtl/pc_fetch_sequencer.sv
// Fetch-stage sequencer: drives PC load/select, IF/ID hold/flush and ID/EX bubble
// for branch squash, load-use stall and halt, with saturating flush/stall counters.
module pc_fetch_sequencer #(
  parameter int FLUSH_CYCLES = 2,
  parameter int LOAD_STALL   = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             br_taken,
  input  logic [63:0]      br_target,
  input  logic             stall_req,
  input  logic             halt_req,
  output logic             pc_wr_en,
  output logic             pc_sel,
  output logic [63:0]      pc_taken,
  output logic             ifid_wr_en,
  output logic             flush_ifid,
  output logic             bubble_idex,
  output logic             halted,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FLUSH = 2'd1,
    S_STALL = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam int CMAX = (FLUSH_CYCLES > LOAD_STALL) ? FLUSH_CYCLES : LOAD_STALL;
  localparam int CW   = (CMAX < 2) ? 1 : $clog2(CMAX);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          flush_inc, stall_inc;

  // State register and saturating performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_RUN;
      cnt       <= '0;
      flush_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (flush_inc && (flush_cnt != {CNT_W{1'b1}}))
        flush_cnt <= flush_cnt + CNT_W'(1);
      if (stall_inc && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  // The request cycle itself is the first squashed/held cycle, so FLUSH/STALL
  // run for the remaining N-1 cycles and leave when cnt decrements to zero.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      S_RUN: begin
        if (br_taken) begin
          if (FLUSH_CYCLES > 1) begin
            state_n = S_FLUSH;
            cnt_n   = CW'(FLUSH_CYCLES - 1);
          end
        end else if (halt_req) begin
          state_n = S_HALT;
        end else if (stall_req) begin
          if (LOAD_STALL > 1) begin
            state_n = S_STALL;
            cnt_n   = CW'(LOAD_STALL - 1);
          end
        end
      end
      S_FLUSH, S_STALL: begin
        if (cnt <= CW'(1)) begin
          state_n = S_RUN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      S_HALT:  state_n = S_HALT;
      default: state_n = S_RUN;
    endcase
  end

  always_comb begin
    pc_wr_en    = 1'b0;
    pc_sel      = 1'b0;
    ifid_wr_en  = 1'b0;
    flush_ifid  = 1'b0;
    bubble_idex = 1'b0;
    halted      = 1'b0;
    if (reset) begin
      flush_ifid  = 1'b1;
      bubble_idex = 1'b1;
    end else begin
      case (state)
        S_RUN: begin
          if (br_taken) begin
            pc_wr_en    = 1'b1;
            pc_sel      = 1'b1;
            ifid_wr_en  = 1'b1;
            flush_ifid  = 1'b1;
            bubble_idex = 1'b1;
          end else if (halt_req || stall_req) begin
            bubble_idex = 1'b1;
          end else begin
            pc_wr_en   = 1'b1;
            ifid_wr_en = 1'b1;
          end
        end
        S_FLUSH: begin
          pc_wr_en    = 1'b1;
          ifid_wr_en  = 1'b1;
          flush_ifid  = 1'b1;
          bubble_idex = 1'b1;
        end
        S_STALL: bubble_idex = 1'b1;
        S_HALT: begin
          bubble_idex = 1'b1;
          halted      = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign pc_taken  = br_target;
  assign dbg_state = state;
  assign flush_inc = !reset && flush_ifid;
  assign stall_inc = !reset && !pc_wr_en && ((state == S_RUN) || (state == S_STALL));

endmodule
